bist_tpg: RTL and testbench

Built-in self-test pattern generator that sits directly upstream of a small sequential benchmark circuit-under-test (CUT) and drives its primary inputs. On a start request it emits a fixed number of pseudo-random patterns, one per clock, from a Fibonacci LFSR, then reports completion. A downstream response compactor uses PAT_VALID to qualify capture of the CUT output.

---
 rtl/bist_tpg_if.sv | 24 ++
 rtl/bist_tpg.sv | 78 +++++++
 tb/tb_bist_tpg.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bist_tpg_if.sv
// Bus between the BIST pattern generator and its controller/CUT side.
// start/hold come from the controller; pat is a live test pattern exactly while pat_valid is high.
interface bist_tpg_if #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned CW    = 8
);
   logic             start;
   logic             hold;
   logic [WIDTH-1:0] pat;
   logic             pat_valid;
   logic             busy;
   logic             done;
   logic [CW-1:0]    cnt;

   modport master (
      output start, hold,
      input  pat, pat_valid, busy, done, cnt
   );

   modport slave (
      input  start, hold,
      output pat, pat_valid, busy, done, cnt
   );
endinterface

// File: rtl/bist_tpg.sv
// Fibonacci-LFSR test pattern generator: after START it emits NPAT patterns,
// one per non-stalled clock, then holds the last pattern and reports DONE.
module bist_tpg #(
   parameter int unsigned      WIDTH = 4,
   parameter logic [WIDTH-1:0] POLY  = 4'b1100,
   parameter logic [WIDTH-1:0] SEED  = 4'b0001,
   parameter int unsigned      NPAT  = 15,
   parameter int unsigned      CW    = 8
) (
   input  logic       clk_i,
   input  logic       rst_i,
   bist_tpg_if.slave  bus,
   output logic [1:0] state_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   // An all-zero seed would lock the LFSR, so it is replaced by 1.
   localparam logic [WIDTH-1:0] SEED_EFF = (SEED == '0) ? WIDTH'(1) : SEED;
   localparam logic [CW-1:0]    LAST_CNT = CW'(NPAT - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] pat_q, pat_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         pat_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pat_d   = pat_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (bus.start) begin
               state_d = S_RUN;
               pat_d   = SEED_EFF;
               cnt_d   = '0;
            end
         end
         S_RUN: begin
            // HOLD outranks the terminal-count exit so a stalled last pattern stays valid.
            if (!bus.hold) begin
               if (cnt_q == LAST_CNT) begin
                  state_d = S_DONE;
               end else begin
                  pat_d = {pat_q[WIDTH-2:0], ^(pat_q & POLY)};
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      bus.pat       = pat_q;
      bus.cnt       = cnt_q;
      bus.pat_valid = (state_q == S_RUN);
      bus.busy      = (state_q == S_RUN);
      bus.done      = (state_q == S_DONE);
      state_o       = state_q;
   end

endmodule

// File: tb/tb_bist_tpg.sv
// Randomized bench for bist_tpg: three parameter sets, a pattern scoreboard fed
// by a behavioural LFSR model, and directed checks for stall, restart and reset.
module tb_bist_tpg;
   localparam int W  = 4;
   localparam int CW = 8;
   localparam logic [W-1:0] POLY = 4'b1100;
   localparam int CFG_SEED [3] = '{1, 0, 5};
   localparam int CFG_NPAT [3] = '{15, 20, 1};

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start_a [3];
   logic          hold_a  [3];
   logic [W-1:0]  pat_a   [3];
   logic          valid_a [3];
   logic          busy_a  [3];
   logic          done_a  [3];
   logic [CW-1:0] cnt_a   [3];
   logic [1:0]    state_a [3];

   logic [W+CW-1:0] exp_q[$];
   logic [W-1:0]    last_pat;
   int checks = 0;
   int errors = 0;
   int sel = 0;
   int valid_cycles = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      bist_tpg_if #(.WIDTH(W), .CW(CW)) bus ();
      assign bus.start  = start_a[g];
      assign bus.hold   = hold_a[g];
      assign pat_a[g]   = bus.pat;
      assign valid_a[g] = bus.pat_valid;
      assign busy_a[g]  = bus.busy;
      assign done_a[g]  = bus.done;
      assign cnt_a[g]   = bus.cnt;
      bist_tpg #(
         .WIDTH(W), .POLY(POLY), .SEED(W'(CFG_SEED[g])),
         .NPAT(CFG_NPAT[g]), .CW(CW)
      ) dut (
         .clk_i(clk), .rst_i(rst), .bus(bus), .state_o(state_a[g])
      );
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // Reference model: next pattern shifts left and appends the parity of the tapped bits.
   function automatic logic [W-1:0] lfsr_step(input logic [W-1:0] p);
      int taps;
      taps = $countones(p & POLY);
      return {p[W-2:0], taps[0]};
   endfunction

   task automatic push_run(input int s);
      logic [W-1:0] p;
      p = (CFG_SEED[s] == 0) ? W'(1) : W'(CFG_SEED[s]);
      for (int k = 0; k < CFG_NPAT[s]; k++) begin
         exp_q.push_back({CW'(k), p});
         last_pat = p;
         p = lfsr_step(p);
      end
   endtask

   // Monitor: every valid cycle is compared against the queue head; the head is
   // retired only when the coming edge is not stalled.
   always @(negedge clk) begin
      if (!rst && valid_a[sel]) begin
         valid_cycles++;
         check("busy_with_valid", 32'(busy_a[sel]), 32'd1);
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_pattern: actual cnt=%0d pat=%b required no pattern", cnt_a[sel], pat_a[sel]);
         end else begin
            check("pattern", 32'({cnt_a[sel], pat_a[sel]}), 32'(exp_q[0]));
            if (!hold_a[sel]) void'(exp_q.pop_front());
         end
         if (sel == 1 && cnt_a[1] == 0)  check("zero_seed_first", 32'(pat_a[1]), 32'd1);
         if (sel == 1 && cnt_a[1] == 15) check("wrap_pat15", 32'(pat_a[1]), 32'd1);
      end
   end

   task automatic start_run(output int start_cyc);
      valid_cycles = 0;
      push_run(sel);
      start_a[sel] = 1'b1;
      @(posedge clk); #1;
      start_a[sel] = 1'b0;
      start_cyc = cyc;
   endtask

   task automatic wait_done(input bit rand_ctl, inout int holds);
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < 300 && !seen; n++) begin
         if (done_a[sel]) begin
            seen = 1'b1;
         end else begin
            if (rand_ctl) begin
               start_a[sel] = 1'($urandom_range(0, 1));
               hold_a[sel]  = ($urandom_range(0, 3) == 0);
               if (hold_a[sel]) holds++;
            end
            @(posedge clk); #1;
         end
      end
      start_a[sel] = 1'b0;
      hold_a[sel]  = 1'b0;
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: actual done=0 after 300 cycles required done=1");
      end
   endtask

   task automatic check_done(input int start_cyc, input int holds);
      check("done_flag", 32'(done_a[sel]), 32'd1);
      check("done_valid", 32'(valid_a[sel]), 32'd0);
      check("done_busy", 32'(busy_a[sel]), 32'd0);
      check("done_state", 32'(state_a[sel]), 32'd2);
      check("done_pat", 32'(pat_a[sel]), 32'(last_pat));
      check("done_cnt", 32'(cnt_a[sel]), 32'(CFG_NPAT[sel] - 1));
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      check("valid_cycles", 32'(valid_cycles), 32'(CFG_NPAT[sel] + holds));
      check("done_latency", 32'(cyc - start_cyc), 32'(CFG_NPAT[sel] + holds));
      hold_a[sel] = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      hold_a[sel] = 1'b0;
      check("done_held", 32'({done_a[sel], valid_a[sel], pat_a[sel]}), 32'({2'b10, last_pat}));
   endtask

   initial begin
      int sc;
      int holds;
      bit reached;
      bit done_seen;
      for (int i = 0; i < 3; i++) begin
         start_a[i] = 1'b0;
         hold_a[i]  = 1'b0;
      end

      // Reset with random noise on the control inputs.
      rst = 1'b1;
      repeat (3) begin
         for (int i = 0; i < 3; i++) begin
            start_a[i] = 1'($urandom_range(0, 1));
            hold_a[i]  = 1'($urandom_range(0, 1));
         end
         @(posedge clk); #1;
      end
      for (int i = 0; i < 3; i++) begin
         check("rst_outputs", 32'({pat_a[i], cnt_a[i], valid_a[i], busy_a[i], done_a[i]}), 32'd0);
         check("rst_state", 32'(state_a[i]), 32'd0);
         start_a[i] = 1'b0;
         hold_a[i]  = 1'b0;
      end
      rst = 1'b0;
      @(posedge clk); #1;

      // Full default run.
      sel = 0;
      holds = 0;
      start_run(sc);
      wait_done(1'b0, holds);
      check_done(sc, holds);
      check("default_last_literal", 32'(pat_a[0]), 32'h8);

      // Restart from DONE, START held during RUN, then a 3-cycle stall at CNT=5.
      start_run(sc);
      check("restart_pat", 32'(pat_a[0]), 32'h1);
      check("restart_cnt", 32'(cnt_a[0]), 32'd0);
      check("restart_done", 32'(done_a[0]), 32'd0);
      start_a[0] = 1'b1;
      reached = 1'b0;
      for (int n = 0; n < 40 && !reached; n++) begin
         if (cnt_a[0] == 5) reached = 1'b1;
         else begin
            @(posedge clk); #1;
         end
      end
      check("reach_cnt5", 32'(reached), 32'd1);
      start_a[0] = 1'b0;
      hold_a[0]  = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         check("stall_pat", 32'(pat_a[0]), 32'h6);
         check("stall_cnt", 32'(cnt_a[0]), 32'd5);
         check("stall_valid", 32'(valid_a[0]), 32'd1);
      end
      hold_a[0] = 1'b0;
      @(posedge clk); #1;
      check("resume_pat", 32'(pat_a[0]), 32'hD);
      holds = 3;
      wait_done(1'b0, holds);
      check_done(sc, holds);

      // Reset in the middle of a run.
      start_run(sc);
      reached = 1'b0;
      for (int n = 0; n < 40 && !reached; n++) begin
         if (cnt_a[0] == 7) reached = 1'b1;
         else begin
            @(posedge clk); #1;
         end
      end
      check("reach_cnt7", 32'(reached), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_q.delete();
      check("midrst_outputs", 32'({pat_a[0], cnt_a[0], valid_a[0], busy_a[0], done_a[0]}), 32'd0);
      check("midrst_state", 32'(state_a[0]), 32'd0);
      done_seen = 1'b0;
      repeat (20) begin
         @(posedge clk); #1;
         if (done_a[0] || valid_a[0]) done_seen = 1'b1;
      end
      check("no_done_after_rst", 32'(done_seen), 32'd0);

      // Randomized runs with random HOLD and START noise.
      repeat (3) begin
         holds = 0;
         start_run(sc);
         wait_done(1'b1, holds);
         check_done(sc, holds);
      end

      // Zero seed substitution and wrap beyond the LFSR period.
      sel = 1;
      holds = 0;
      start_run(sc);
      wait_done(1'b1, holds);
      check_done(sc, holds);

      // Single-pattern run.
      sel = 2;
      holds = 0;
      start_run(sc);
      check("single_pat", 32'(pat_a[2]), 32'h5);
      check("single_valid", 32'(valid_a[2]), 32'd1);
      wait_done(1'b0, holds);
      check_done(sc, holds);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
